// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - register map and hex glyph table shared by the seven-segment scan controller
package seg_pkg;

    localparam logic [1:0] SEG_ADDR_VALUE = 2'd0;
    localparam logic [1:0] SEG_ADDR_BLANK = 2'd1;
    localparam logic [1:0] SEG_ADDR_DP    = 2'd2;
    localparam logic [1:0] SEG_ADDR_BLINK = 2'd3;

    // Glyphs are g..a, active-high; entry 15 is listed first.
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
        return SEG_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble to seven-segment glyph lookup
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = seg_glyph(nibble);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - memory-mapped multiplexed seven-segment scanner; blink via SEG_SCAN_BLINK_EN
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 2,
    parameter int ACTIVE_LOW   = 0,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [31:0]       wr_data,
    output logic [DIGITS-1:0] ena,
    output logic [7:0]        seg
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [DIGITS-1:0] ENA_OFF = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   dp_q;

    logic [CW-1:0] slot_cnt;
    logic [IW-1:0] digit_idx;
    logic          slot_last;
    logic          digit_last;
    logic          frame_wrap;

    logic [DIGITS-1:0] hide_mask;
    logic [3:0]        nibble;
    logic [6:0]        glyph;
    logic              lit;
    logic              hidden;
    logic [DIGITS-1:0] ena_next;
    logic [7:0]        seg_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            blank_q <= '0;
            dp_q    <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                SEG_ADDR_VALUE: value_q <= wr_data[4*DIGITS-1:0];
                SEG_ADDR_BLANK: blank_q <= wr_data[DIGITS-1:0];
                SEG_ADDR_DP:    dp_q    <= wr_data[DIGITS-1:0];
                default: ;
            endcase
        end
    end

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign digit_last = (digit_idx == DIGIT_LAST);
    assign frame_wrap = slot_last && digit_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_last) begin
            slot_cnt  <= '0;
            digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    logic [DIGITS-1:0] blink_q;
    logic [FW-1:0]     frame_cnt;
    logic              blink_phase_on;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_q <= '0;
        end else if (wr_en && (wr_addr == SEG_ADDR_BLINK)) begin
            blink_q <= wr_data[DIGITS-1:0];
        end
    end

    // Phase only moves on whole frames; rewriting the mask keeps the phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt      <= '0;
            blink_phase_on <= 1'b1;
        end else if (frame_wrap) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt      <= '0;
                blink_phase_on <= ~blink_phase_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign hide_mask = blank_q | (blink_phase_on ? {DIGITS{1'b0}} : blink_q);
`else
    assign hide_mask = blank_q;
`endif

    // Upper write-data bits and the frame-length constant are intentionally dropped in narrow builds.
    logic unused_ok;
    assign unused_ok = &{1'b0, wr_data, frame_wrap, FRAME_LAST};

    assign nibble = value_q[{digit_idx, 2'b00} +: 4];

    seg_hex_decode u_hex_decode (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        lit      = (32'(slot_cnt) >= 32'(GUARD));
        hidden   = hide_mask[digit_idx];
        ena_next = lit ? (DIGITS'(1) << digit_idx) : {DIGITS{1'b0}};
        seg_next = hidden ? 8'h00 : {dp_q[digit_idx], glyph};
    end

    // Polarity is folded in at the register so the pins never glitch between stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ena <= ENA_OFF;
            seg <= SEG_OFF;
        end else begin
            ena <= ena_next ^ ENA_OFF;
            seg <= seg_next ^ SEG_OFF;
        end
    end

endmodule
